// File: rtl/sar_search.sv
// Successive-approximation search engine: binary-searches a hidden comparator operand MSB-first.
// Optional signed (offset-domain) search is enabled by defining SAR_SIGNED_SEARCH_EN.
module sar_search #(
  parameter int WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
`ifdef SAR_SIGNED_SEARCH_EN
  input  logic                       signed_mode,
`endif
  output logic [WIDTH-1:0]           probe,
  output logic                       probe_valid,
  input  logic                       cmp_valid,
  input  logic                       cmp_lt,
  input  logic                       cmp_ltu,
  input  logic                       cmp_eq,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           found,
  output logic                       exact,
  output logic [$clog2(WIDTH+1)-1:0] steps
);

  localparam int IW = $clog2(WIDTH);
  localparam int SW = $clog2(WIDTH+1);
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_acc;
  logic [IW-1:0]    r_idx;
  logic [SW-1:0]    r_steps;
  logic [WIDTH-1:0] r_found;
  logic             r_exact;
  logic             w_signedMode;
  logic [WIDTH-1:0] w_candidate;
  logic [WIDTH-1:0] w_flip;
  logic [WIDTH-1:0] w_probe;
  logic [WIDTH-1:0] w_accNext;
  logic             w_less;
  logic             w_accept;
  logic             w_last;
  logic             w_start;

`ifdef SAR_SIGNED_SEARCH_EN
  logic r_signedMode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_signedMode <= 1'b0;
    else if (w_start)
      r_signedMode <= signed_mode;
  end

  assign w_signedMode = r_signedMode;
`else
  logic w_unusedLt;

  assign w_unusedLt   = cmp_lt;
  assign w_signedMode = 1'b0;
`endif

  // Signed search works on offset-binary values so the unsigned SAR walk still applies.
  assign w_candidate = r_acc | (WIDTH'(1) << r_idx);
  assign w_flip      = w_signedMode ? MSB : '0;
  assign w_probe     = w_candidate ^ w_flip;
  assign w_less      = w_signedMode ? cmp_lt : cmp_ltu;
  assign w_accNext   = w_less ? r_acc : w_candidate;
  assign w_accept    = (r_state == S_PROBE) && cmp_valid;
  assign w_last      = (r_idx == '0);
  assign w_start     = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_PROBE;
      S_PROBE: if (w_accept && (cmp_eq || w_last)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_idx   <= '0;
      r_steps <= '0;
      r_found <= '0;
      r_exact <= 1'b0;
    end else if (w_start) begin
      r_acc   <= '0;
      r_idx   <= IW'(WIDTH-1);
      r_steps <= '0;
      r_exact <= 1'b0;
    end else if (w_accept) begin
      r_steps <= r_steps + SW'(1);
      if (cmp_eq) begin
        r_found <= w_probe;
        r_exact <= 1'b1;
      end else begin
        r_acc <= w_accNext;
        if (w_last)
          r_found <= w_accNext ^ w_flip;
        else
          r_idx <= r_idx - IW'(1);
      end
    end
  end

  assign probe       = (r_state == S_PROBE) ? w_probe : '0;
  assign probe_valid = (r_state == S_PROBE);
  assign busy        = (r_state == S_PROBE);
  assign done        = (r_state == S_DONE);
  assign found       = r_found;
  assign exact       = r_exact;
  assign steps       = r_steps;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: table vectors, reset/glitch sequences and random targets
// checked against a closed-form model of the binary search.
module tb_sar_search;

  localparam int WIDTH = 6;
  localparam int SW    = $clog2(WIDTH+1);
  localparam int MSBV  = 1 << (WIDTH-1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] probe;
  logic             probe_valid;
  logic             cmp_valid;
  logic             cmp_lt;
  logic             cmp_ltu;
  logic             cmp_eq;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] found;
  logic             exact;
  logic [SW-1:0]    steps;
  logic             signedMode;
  logic [WIDTH-1:0] target;
  logic             spurious;
  int               waitCycles;
  int               waitCnt;
  int               errors = 0;
  int               checks = 0;

  typedef struct {
    int    target;
    int    waitN;
    int    sMode;
    bit    glitch;
    int    expFound;
    int    expExact;
    int    expSteps;
    string name;
  } vec_t;

  vec_t vecs[$];

  sar_search #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
`ifdef SAR_SIGNED_SEARCH_EN
    .signed_mode (signedMode),
`endif
    .probe       (probe),
    .probe_valid (probe_valid),
    .cmp_valid   (cmp_valid),
    .cmp_lt      (cmp_lt),
    .cmp_ltu     (cmp_ltu),
    .cmp_eq      (cmp_eq),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .exact       (exact),
    .steps       (steps)
  );

  always #5 clk = ~clk;

  // Comparator responder: answers after waitCycles idle cycles of each probe.
  assign cmp_eq    = (target == probe);
  assign cmp_ltu   = (target < probe);
  assign cmp_lt    = ($signed(target) < $signed(probe));
  assign cmp_valid = (probe_valid && (waitCnt >= waitCycles)) || spurious;

  always @(posedge clk) begin
    if (!probe_valid || cmp_valid)
      waitCnt <= 0;
    else
      waitCnt <= waitCnt + 1;
  end

  // Model: the n-th probe keeps the target's bits above position i and sets bit i.
  function automatic int modelProbe(input int tgt, input int sMode, input int n);
    int t;
    int i;
    int p;
    t = sMode ? (tgt ^ MSBV) : tgt;
    i = WIDTH - 1 - n;
    p = ((t >> (i + 1)) << (i + 1)) | (1 << i);
    return sMode ? (p ^ MSBV) : p;
  endfunction

  function automatic int modelSteps(input int tgt, input int sMode);
    int t;
    t = sMode ? (tgt ^ MSBV) : tgt;
    if (t == 0) return WIDTH;
    for (int b = 0; b < WIDTH; b++)
      if (t[b]) return WIDTH - b;
    return WIDTH;
  endfunction

  function automatic int modelExact(input int tgt, input int sMode);
    int t;
    t = sMode ? (tgt ^ MSBV) : tgt;
    return (t != 0) ? 1 : 0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int cyc;
    int n;
    int heldProbe;
    bit waiting;
    bit seenDone;
    target     = WIDTH'(v.target);
    waitCycles = v.waitN;
    signedMode = v.sMode[0];
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    cyc       = 1;
    n         = 0;
    waiting   = 1'b0;
    seenDone  = 1'b0;
    heldProbe = 0;
    while (!seenDone && cyc < 400) begin
      start = v.glitch && (cyc == 2 || cyc == 3);
      if (done) begin
        seenDone = 1'b1;
      end else begin
        checkOutput({v.name, " busy"}, int'(busy && probe_valid), 1);
        if (waiting)
          checkOutput({v.name, " held probe"}, int'(probe), heldProbe);
        if (cmp_valid) begin
          checkOutput($sformatf("%s probe%0d", v.name, n), int'(probe),
                      modelProbe(v.target, v.sMode, n));
          n++;
          waiting = 1'b0;
        end else begin
          waiting   = 1'b1;
          heldProbe = int'(probe);
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!seenDone) begin
      checkOutput({v.name, " done timeout"}, 0, 1);
      start = 1'b0;
      return;
    end
    checkOutput({v.name, " done cycle"}, cyc, v.expSteps * (v.waitN + 1) + 1);
    checkOutput({v.name, " found"}, int'(found), v.expFound);
    checkOutput({v.name, " exact"}, int'(exact), v.expExact);
    checkOutput({v.name, " steps"}, int'(steps), v.expSteps);
    checkOutput({v.name, " probes"}, n, v.expSteps);
    checkOutput({v.name, " idle in done"}, int'(busy || probe_valid), 0);
    start = v.glitch;
    @(negedge clk);
    start = 1'b0;
    checkOutput({v.name, " done pulse"}, int'(done), 0);
    checkOutput({v.name, " no restart"}, int'(busy), 0);
    checkOutput({v.name, " found held"}, int'(found), v.expFound);
  endtask

  initial begin
    vec_t v;
    rst_n      = 1'b0;
    start      = 1'b0;
    spurious   = 1'b0;
    signedMode = 1'b0;
    target     = '0;
    waitCycles = 0;

    vecs.push_back('{32, 0, 0, 1'b0, 32, 1, 1, "t32"});
    vecs.push_back('{63, 0, 0, 1'b0, 63, 1, 6, "t63"});
    vecs.push_back('{0,  0, 0, 1'b0, 0,  0, 6, "t0"});
    vecs.push_back('{21, 3, 0, 1'b0, 21, 1, 6, "t21wait3"});
    vecs.push_back('{40, 1, 0, 1'b1, 40, 1, 3, "t40glitch"});
    vecs.push_back('{32, 0, 0, 1'b1, 32, 1, 1, "t32glitch"});
`ifdef SAR_SIGNED_SEARCH_EN
    vecs.push_back('{63, 0, 1, 1'b0, 63, 1, 6, "signedM1"});
    vecs.push_back('{32, 0, 1, 1'b0, 32, 0, 6, "signedMin"});
`endif

    repeat (2) @(negedge clk);
    checkOutput("reset probe", int'(probe), 0);
    checkOutput("reset probe_valid", int'(probe_valid), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset found", int'(found), 0);
    checkOutput("reset exact", int'(exact), 0);
    checkOutput("reset steps", int'(steps), 0);
    rst_n = 1'b1;

    // A response with no probe outstanding must not move anything.
    @(negedge clk);
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("spurious busy", int'(busy), 0);
    checkOutput("spurious steps", int'(steps), 0);
    checkOutput("spurious done", int'(done), 0);
    spurious = 1'b0;

    foreach (vecs[k]) applyStimulus(vecs[k]);

    // Reset mid-search after three accepted probes, then a clean rerun.
    target     = WIDTH'(45);
    waitCycles = 0;
    signedMode = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre-reset steps", int'(steps), 3);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset probe", int'(probe), 0);
    checkOutput("midreset valid", int'(probe_valid), 0);
    checkOutput("midreset busy", int'(busy), 0);
    checkOutput("midreset steps", int'(steps), 0);
    checkOutput("midreset exact", int'(exact), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("midreset no done", int'(done || busy), 0);
    end
    rst_n = 1'b1;
    v = '{45, 0, 0, 1'b0, 45, 1, 6, "t45rerun"};
    applyStimulus(v);

    for (int r = 0; r < 20; r++) begin
      v.target = int'($urandom_range(0, (1 << WIDTH) - 1));
      v.waitN  = int'($urandom_range(0, 2));
`ifdef SAR_SIGNED_SEARCH_EN
      v.sMode  = int'($urandom_range(0, 1));
`else
      v.sMode  = 0;
`endif
      v.glitch   = ($urandom_range(0, 3) == 0);
      v.expFound = v.target;
      v.expExact = modelExact(v.target, v.sMode);
      v.expSteps = modelSteps(v.target, v.sMode);
      v.name     = $sformatf("rand%0d_t%0d_s%0d", r, v.target, v.sMode);
      applyStimulus(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
